tt_um_unload: RTL and testbench
===============================

# tt_um_unload

Weight readback serializer: the transmit-side counterpart of the weight loader. It snapshots the full ternary weight array and streams it out MAX_IN_LEN bits per beat, in exactly the bit order the loader consumes. A loader fed by this block reproduces the original array. It sits beside the loader and weight store, serving debug readback and chip-to-chip weight transfer over the 16-bit pin bus.

## Interface
- MAX_IN_LEN, 16: bits per beat; number of input rows.
- MAX_OUT_LEN, 8: output columns.
- WIDTH, 2: bits per ternary weight.
- BEATS, WIDTH*MAX_OUT_LEN (16): beats per frame.
- BEAT_BITS, $clog2(BEATS) (4): beat counter width.
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- ena, input, 1: block enable. When low, all state is frozen and start is ignored.
- ui_start, input, 1: request a frame. Sampled only in IDLE.
- ui_weights, input, WIDTH*MAX_IN_LEN*MAX_OUT_LEN (256): weight array to send.
- ui_ready, input, 1: downstream accepts the current beat.
- uo_output, output, MAX_IN_LEN (16): beat data.
- uo_valid, output, 1: uo_output holds a valid beat.
- uo_busy, output, 1: frame in progress.
- uo_done, output, 1: one-cycle pulse after the last beat is accepted.

## Operation
- State machine has two states, IDLE and SEND. Registers: beat[BEAT_BITS-1:0], snap[255:0], done_q.
- Reset, while rst_n is low: state=IDLE, beat=0, snap=0, done_q=0. Resulting outputs: uo_output=0, uo_valid=0, uo_busy=0, uo_done=0.
- IDLE, on an edge with ena && ui_start:
  - snap <= ui_weights;
  - beat <= 0;
  - go to SEND.
- Later changes on ui_weights do not affect the frame in flight.
- SEND, on an edge with ena && ui_ready (a beat is accepted):
  - if beat != BEATS-1: beat <= beat+1;
  - if beat == BEATS-1: beat <= 0, go to IDLE, done_q <= 1.
- done_q clears on the next ena edge. It holds while ena is low.
- ui_start in SEND is ignored. It is not queued.
- Beat mapping, the inverse of the loader: uo_output[i] = snap[i*BEATS + beat] for i in 0..MAX_IN_LEN-1. Row i's 16 bits go out LSB-first, one per beat.
- Output logic:
  - uo_output is forced to 0 when uo_valid=0.
  - uo_valid = uo_busy = (state==SEND).
  - uo_done = done_q.
- ena=0 in SEND: beat is not advanced even if ui_ready=1. uo_valid stays 1 and data is held.

## Timing
- Start to first beat: 1 cycle. Start is sampled at edge N, uo_valid=1 with beat 0 data after edge N.
- Full throughput: with ui_ready=1 and ena=1 throughout, a frame takes exactly BEATS (16) cycles of uo_valid=1.
- uo_done is high in the cycle immediately after the edge that accepts beat BEATS-1. uo_valid is 0 in that same cycle.
- Back-to-back frames: ui_start high during the uo_done cycle is accepted. This gives 1 idle cycle between frames.
- Backpressure: while ui_ready=0, uo_output and uo_valid are stable. No beat is lost or repeated.
- Async reset mid-frame: outputs go to reset values immediately, without waiting for clk. The frame is abandoned, and after release the block is in IDLE.
- The beat counter never wraps inside a frame. The BEATS-1 to 0 transition coincides with leaving SEND.

## Test plan
- Diagonal pattern: ui_weights bit (i*16+c) set iff c==i. Start with ui_ready=1 -> beat c shows uo_output=16'h1<<c for c=0..15, then uo_done=1 for one cycle, uo_busy=0.
- Coherent snapshot: start with ui_weights=all ones, then drive ui_weights=0 in the next cycle -> all 16 beats read 16'hFFFF.
- Backpressure: toggle ui_ready 1,0,0,1,... pseudo-randomly with random weights -> the accepted beats, fed into the loader, reproduce ui_weights exactly. Output is stable while ui_ready=0.
- Enable and start filtering:
  - hold ena=0 for 3 cycles at beat 5 -> beat stays 5;
  - assert ui_start mid-frame -> no restart, total accepted beats = 16.
- Reset mid-frame: assert rst_n=0 at beat 9 -> uo_valid, uo_busy, uo_done and uo_output drop to 0 asynchronously. A subsequent start begins at beat 0.
- Back-to-back: ui_start held high with ui_ready=1 -> frames of 16 valid cycles separated by exactly 1 done cycle.

Source files
------------

// File: rtl/tt_um_unload.sv
// Weight readback serializer. It snapshots the ternary weight array and streams it
// out one MAX_IN_LEN-bit beat per accepted cycle, in the order the weight loader consumes.
module tt_um_unload #(
   parameter int MAX_IN_LEN  = 16,
   parameter int MAX_OUT_LEN = 8,
   parameter int WIDTH       = 2,
   parameter int BEATS       = WIDTH * MAX_OUT_LEN,
   parameter int BEAT_BITS   = $clog2(BEATS)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    ena,
   input  logic                                    ui_start,
   input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
   input  logic                                    ui_ready,
   output logic [MAX_IN_LEN-1:0]                   uo_output,
   output logic                                    uo_valid,
   output logic                                    uo_busy,
   output logic                                    uo_done
);

   localparam int SNAP_BITS = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
   localparam logic [BEAT_BITS-1:0] ONE_BEAT  = BEAT_BITS'(1);

   logic [0:0]           state;
   logic [BEAT_BITS-1:0] beat;
   logic [SNAP_BITS-1:0] snap;
   logic                 done_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the snapshot is a plain register, so it is reset like the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         beat   <= '0;
         snap   <= '0;
         done_q <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (ui_start) begin
                  snap  <= ui_weights;
                  beat  <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               // ui_start is deliberately not looked at here: no restart, no queueing.
               if (ui_ready) begin
                  if (beat == LAST_BEAT) begin
                     beat   <= '0;
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end else begin
                     beat <= beat + ONE_BEAT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Row i's bits leave LSB-first, one per beat, so bit i of each beat is snap[i*BEATS+beat].
   always_comb begin
      uo_output = '0;
      if (state == SEND) begin
         for (int i = 0; i < MAX_IN_LEN; i++) begin
            uo_output[i] = snap[i*BEATS + int'(beat)];
         end
      end
   end

   assign uo_valid = (state == SEND);
   assign uo_busy  = (state == SEND);
   assign uo_done  = done_q;

endmodule

// File: tb/tb_tt_um_unload.sv
// Directed bench for tt_um_unload: outputs are sampled on the falling edge and
// inputs are changed right after sampling, ahead of the next rising edge.
module tb_tt_um_unload;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic         ui_start;
   logic [255:0] ui_weights;
   logic         ui_ready;
   logic [15:0]  uo_output;
   logic         uo_valid;
   logic         uo_busy;
   logic         uo_done;

   int tests_run;
   int tests_failed;

   logic [255:0] diag;

   tt_um_unload dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .ui_start  (ui_start),
      .ui_weights(ui_weights),
      .ui_ready  (ui_ready),
      .uo_output (uo_output),
      .uo_valid  (uo_valid),
      .uo_busy   (uo_busy),
      .uo_done   (uo_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise ui_start for one rising edge; returns just after that edge (beat 0 visible).
   task automatic start_frame(input logic [255:0] w);
      @(negedge clk);
      ui_weights = w;
      ui_start   = 1'b1;
      @(negedge clk);
      ui_start   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n      = 1'b0;
      ena        = 1'b1;
      ui_start   = 1'b1;
      ui_ready   = 1'b1;
      ui_weights = {8{32'hDEAD_BEEF}};
      repeat (2) @(negedge clk);
      tests_run++;
      if ({uo_output, uo_valid, uo_busy, uo_done} !== 19'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got out=%h v=%b b=%b d=%b, want all 0",
                  uo_output, uo_valid, uo_busy, uo_done);
      end
      ui_start = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      tests_run++;
      if (uo_valid !== 1'b0 || uo_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got v=%b b=%b, want 0 0", uo_valid, uo_busy);
      end
   endtask

   task automatic test_diagonal;
      ui_ready = 1'b1;
      start_frame(diag);
      for (int c = 0; c < 16; c++) begin
         tests_run++;
         if (uo_valid !== 1'b1 || uo_output !== (16'h1 << c)) begin
            tests_failed++;
            $display("FAIL diag_beat%0d: got v=%b out=%h, want v=1 out=%h",
                     c, uo_valid, uo_output, 16'h1 << c);
         end
         @(negedge clk);
      end
      tests_run++;
      if (uo_done !== 1'b1 || uo_valid !== 1'b0 || uo_busy !== 1'b0 || uo_output !== 16'h0) begin
         tests_failed++;
         $display("FAIL diag_done: got d=%b v=%b b=%b out=%h, want d=1 v=0 b=0 out=0",
                  uo_done, uo_valid, uo_busy, uo_output);
      end
      @(negedge clk);
      tests_run++;
      if (uo_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL diag_done_pulse: got d=%b one cycle later, want 0", uo_done);
      end
   endtask

   task automatic test_snapshot;
      int bad;
      bad = 0;
      ui_ready = 1'b1;
      start_frame({256{1'b1}});
      ui_weights = '0;
      for (int c = 0; c < 16; c++) begin
         if (uo_valid !== 1'b1 || uo_output !== 16'hFFFF) bad++;
         @(negedge clk);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL snapshot: got %0d beats not FFFF/valid, want 0", bad);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [255:0] w;
      logic [255:0] rx;
      logic [15:0]  held;
      logic         held_valid;
      int           accepted;
      int           unstable;
      int           cyc;
      bit           seen_done;
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
      rx         = '0;
      accepted   = 0;
      unstable   = 0;
      held_valid = 1'b0;
      held       = '0;
      seen_done  = 1'b0;
      start_frame(w);
      cyc = 0;
      while (!seen_done && cyc < 200) begin
         if (held_valid && (uo_valid !== 1'b1 || uo_output !== held)) unstable++;
         if (uo_done === 1'b1) seen_done = 1'b1;
         if (uo_valid === 1'b1) begin
            ui_ready = (cyc < 4) ? ((cyc == 0 || cyc == 3) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
            if (ui_ready) begin
               // Loader view: bit i of accepted beat n is weight bit i*16+n.
               for (int i = 0; i < 16; i++) rx[i*16 + accepted] = uo_output[i];
               accepted++;
               held_valid = 1'b0;
            end else begin
               held       = uo_output;
               held_valid = 1'b1;
            end
         end
         @(negedge clk);
         cyc++;
      end
      ui_ready = 1'b1;
      tests_run++;
      if (!seen_done || accepted != 16) begin
         tests_failed++;
         $display("FAIL bp_count: got accepted=%0d done_seen=%0b, want 16 1", accepted, seen_done);
      end
      tests_run++;
      if (unstable != 0) begin
         tests_failed++;
         $display("FAIL bp_stable: got %0d unstable stalled cycles, want 0", unstable);
      end
      tests_run++;
      if (rx !== w) begin
         tests_failed++;
         $display("FAIL bp_reload: got %h, want %h", rx, w);
      end
   endtask

   task automatic test_enable_and_start;
      int accepted;
      int cyc;
      int bad;
      ui_ready = 1'b1;
      start_frame(diag);
      repeat (5) @(negedge clk);
      ena = 1'b0;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (uo_valid !== 1'b1 || uo_output !== 16'h0020) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL ena_hold: got %0d cycles off beat 5 (out=%h), want 0", bad, uo_output);
      end
      ena      = 1'b1;
      accepted = 5;
      cyc      = 0;
      bad      = 0;
      while (uo_valid === 1'b1 && cyc < 40) begin
         if (uo_output !== (16'h1 << accepted)) bad++;
         ui_start = (accepted == 8);
         accepted++;
         @(negedge clk);
         cyc++;
      end
      ui_start = 1'b0;
      tests_run++;
      if (accepted != 16 || bad != 0 || uo_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_ignored: got beats=%0d bad=%0d done=%b, want 16 0 1",
                  accepted, bad, uo_done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe;
      ui_ready = 1'b1;
      start_frame(diag);
      repeat (9) @(negedge clk);
      tests_run++;
      if (uo_output !== 16'h0200) begin
         tests_failed++;
         $display("FAIL rst_pre_beat9: got out=%h, want 0200", uo_output);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({uo_output, uo_valid, uo_busy, uo_done} !== 19'd0) begin
         tests_failed++;
         $display("FAIL rst_async: got out=%h v=%b b=%b d=%b, want all 0",
                  uo_output, uo_valid, uo_busy, uo_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (uo_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_idle_after: got v=%b, want 0", uo_valid);
      end
      start_frame(diag);
      tests_run++;
      if (uo_valid !== 1'b1 || uo_output !== 16'h0001) begin
         tests_failed++;
         $display("FAIL rst_restart_beat0: got v=%b out=%h, want 1 0001", uo_valid, uo_output);
      end
      repeat (17) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int bad;
      bad = 0;
      ui_ready   = 1'b1;
      ui_weights = diag;
      @(negedge clk);
      ui_start = 1'b1;
      @(negedge clk);
      // Frame period is 17 cycles: 16 valid beats then one done cycle.
      for (int k = 0; k < 51; k++) begin
         if ((k % 17) < 16) begin
            if (uo_valid !== 1'b1 || uo_done !== 1'b0 || uo_output !== (16'h1 << (k % 17))) bad++;
         end else begin
            if (uo_valid !== 1'b0 || uo_done !== 1'b1) bad++;
         end
         @(negedge clk);
      end
      ui_start = 1'b0;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL b2b_pattern: got %0d off-pattern cycles, want 0", bad);
      end
      repeat (16) @(negedge clk);
      tests_run++;
      if (uo_done !== 1'b1 || uo_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_last_done: got d=%b v=%b, want 1 0", uo_done, uo_valid);
      end
      @(negedge clk);
      tests_run++;
      if (uo_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: got b=%b, want 0", uo_busy);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      diag = '0;
      for (int i = 0; i < 16; i++) diag[i*16 + i] = 1'b1;
      test_reset();
      test_diagonal();
      test_snapshot();
      test_backpressure();
      test_enable_and_start();
      test_reset_midframe();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
